imm_gen_pipe: RTL
=================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts a 32-bit RISC-V instruction over a valid/ready handshake and extracts and sign-extends its immediate to XLEN bits. It also reports the immediate format and flags illegal immediate encodings. A 2-entry skid buffer sits at the output, so fetch and execute can stall independently without losing instructions.

## Interface
- XLEN, 32: output datapath width; legal values 32 or 64.
- TAG_W, 8: width of the opaque sideband tag (PC index / ROB id) carried alongside each instruction.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts; pop when out_valid && out_ready.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH (shift amount).
- out_illegal  out  1  immediate encoding illegal for this XLEN / unknown opcode.
- out_tag  out  TAG_W  tag of head entry.

## Operation
- Decode is combinational on in_inst; the result {imm, fmt, illegal, tag} is written into the buffer on accept.
- Opcode map (inst[6:0]); sign-extension is always from inst[31] to XLEN unless stated:
  - 0110111 LUI and 0010111 AUIPC: U, {inst[31:12], 12'b0}, sign-extended (matters for XLEN=64).
  - 1101111 JAL: J, {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 1100111 JALR, 0000011 loads: I, inst[31:20].
  - 0100011 stores: S, {inst[31:25], inst[11:7]}.
  - 1100011 branches: B, {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0010011 OP-IMM:
    - funct3 001 or 101 (each compared individually): SH, zero-extended shamt. Shamt is inst[24:20] when XLEN=32 and inst[25:20] when XLEN=64.
    - Shift with XLEN=32 and inst[25]=1: illegal.
    - Otherwise: I.
  - 0011011 OP-IMM-32: legal only when XLEN=64. Same rules as OP-IMM, but shamt is always 5 bits, and inst[25]=1 on a shift is illegal. When XLEN=32 the opcode is illegal.
  - 0110011, 0111011 (XLEN=64 only), 0001111, 1110011: NONE, imm 0, legal.
  - Any other opcode: NONE, imm 0, illegal=1.
- Every illegal result carries imm 0 and fmt NONE.
- Buffer: 2-entry FIFO with a 2-bit occupancy count (0..2), a read pointer and a write pointer.
  - in_ready = rst_n && (count != 2); this is combinational from registered count, with no out_ready→in_ready path.
  - out_valid = (count != 0); out_* driven from the entry at the read pointer.
  - Push only: count+1. Pop only: count−1. Push and pop together (count 1 only): count unchanged, pointers both advance.
  - With count 2, in_ready is 0, so no push occurs; a pop that cycle frees space for the next cycle.
  - Order is strict FIFO; the tag is never reordered.

## Timing
- Latency 1: an instruction accepted at edge N presents on out_* with out_valid=1 after edge N.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Outputs hold stable while out_valid && !out_ready.
- Reset with rst_n=0 at an edge:
  - count, pointers, out_valid → 0; out_imm, out_fmt, out_tag, out_illegal → 0.
  - in_ready = 0 while rst_n=0, and 1 in the first cycle after release.
  - In-flight entries are discarded; any input presented during reset is not accepted.

## Test plan
- LUI 0x800000B7, out_ready=1: XLEN=32 gives imm 0x80000000, fmt 4; XLEN=64 gives 0xFFFFFFFF80000000. out_valid one cycle after accept.
- JAL 0xFF9FF06F gives imm 0xFFFFFFF8 (XLEN=32), fmt 5. SRAI 0x4030D093 gives imm 3, fmt 6 (funct7 bit not leaked).
- SLLI shamt 32, 0x02009093: XLEN=32 gives illegal=1, imm 0, fmt 0; XLEN=64 gives imm 32, fmt 6, illegal=0. Opcode 0x0000007F gives illegal=1 at both widths.
- Backpressure: out_ready=0, present tags 1,2,3 back-to-back. in_ready drops after 2 accepts and tag 3 is held. Then raise out_ready: outputs tags 1,2,3 in order on consecutive cycles, and in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, out_valid continuously 1, tags emerge in order with no bubble.
- Reset mid-operation: count=2, drive rst_n=0 for one edge. out_valid=0 and all outputs 0 next cycle, in_ready=1 after release, and no stale tag ever appears.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts and sign-extends a RISC-V immediate,
// then queues {imm, fmt, illegal, tag} in a 2-entry FIFO toward execute.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and in_ready depends only on registered count and rst_n.

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_fmt;
  logic            d_ill;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    d_imm = '0;
    d_fmt = FMT_NONE;
    d_ill = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        d_fmt = FMT_U;
        d_imm = sext32({in_inst[31:12], 12'b0});
      end
      7'b1101111: begin
        d_fmt = FMT_J;
        d_imm = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0});
      end
      7'b1100111, 7'b0000011: begin
        d_fmt = FMT_I;
        d_imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
      end
      7'b0100011: begin
        d_fmt = FMT_S;
        d_imm = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
      end
      7'b1100011: begin
        d_fmt = FMT_B;
        d_imm = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0});
      end
      7'b0010011: begin
        if (is_shift) begin
          // 6-bit shamt is only meaningful on RV64; bit 25 set on RV32 is reserved.
          if (XLEN == 32 && in_inst[25]) begin
            d_ill = 1'b1;
          end else begin
            d_fmt      = FMT_SH;
            d_imm[5:0] = in_inst[25:20];
          end
        end else begin
          d_fmt = FMT_I;
          d_imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
        end
      end
      7'b0011011: begin
        if (XLEN != 64) begin
          d_ill = 1'b1;
        end else if (is_shift) begin
          if (in_inst[25]) begin
            d_ill = 1'b1;
          end else begin
            d_fmt      = FMT_SH;
            d_imm[4:0] = in_inst[24:20];
          end
        end else begin
          d_fmt = FMT_I;
          d_imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
        end
      end
      7'b0110011, 7'b0001111, 7'b1110011: d_ill = 1'b0;
      7'b0111011: d_ill = (XLEN != 64);
      default:    d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_imm = '0;
      d_fmt = FMT_NONE;
    end
  end

  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic             ill_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       count;
  logic             wptr;
  logic             rptr;
  logic             push;
  logic             pop;

  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_imm     = imm_q[rptr];
  assign out_fmt     = fmt_q[rptr];
  assign out_illegal = ill_q[rptr];
  assign out_tag     = tag_q[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      if (push) begin
        imm_q[wptr] <= d_imm;
        fmt_q[wptr] <= d_fmt;
        ill_q[wptr] <= d_ill;
        tag_q[wptr] <= in_tag;
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
